// File: rtl/shift_register_sipo_receiver.sv
// -----------------------------------------------------------------------------
// shift_register_sipo_receiver
//
// Serial-in, parallel-out receiver for the PISO shift-register link.
// A frame is one start bit (0), WIDTH data bits, an optional even-parity bit
// and one stop bit (1). Sin is sampled only on cycles where bit_en is high.
// A correctly framed word is held on Pout with a valid/ack handshake.
//
// Optional feature macro: SIPO_PARITY_CHECK_EN
//   defined   -> an even-parity bit follows the data bits, parity_err port added
//   undefined -> no parity bit, no parity_err port
//
// Parameters:
//   WIDTH     data bits per frame (2..16)
//   MSB_FIRST 1: first received bit lands in Pout[WIDTH-1]; 0: in Pout[0]
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   bit_en     single-cycle sample strobe for Sin
//   Sin        serial data, idle high (already synchronous to clk)
//   ack        consumer acknowledge, clears valid
//   Pout       last correctly framed data word
//   valid      Pout holds an unacknowledged word
//   busy       frame in progress
//   frame_err  sticky, bad stop bit seen
//   overrun    sticky, a word completed while the previous one was unacknowledged
//   bit_cnt    data bits received in the current frame
//   parity_err sticky, parity mismatch (only with SIPO_PARITY_CHECK_EN)
// -----------------------------------------------------------------------------
module shift_register_sipo_receiver #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bit_en,
  input  logic                     Sin,
  input  logic                     ack,
  output logic [WIDTH-1:0]         Pout,
  output logic                     valid,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     overrun,
  output logic [$clog2(WIDTH):0]   bit_cnt
`ifdef SIPO_PARITY_CHECK_EN
  ,
  output logic                     parity_err
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

`ifdef SIPO_PARITY_CHECK_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_STOP   = 2'd3
  } state_t;
`endif

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   shift_r, shift_s;
  logic [WIDTH-1:0]   pout_r, pout_s;
  logic               valid_r, valid_s;
  logic               busy_r, busy_s;
  logic               frame_err_r, frame_err_s;
  logic               overrun_r, overrun_s;
  logic [CNT_W-1:0]   bit_cnt_r, bit_cnt_s;
`ifdef SIPO_PARITY_CHECK_EN
  logic               par_acc_r, par_acc_s;     // running XOR of data bits
  logic               par_bad_r, par_bad_s;     // current frame failed parity
  logic               parity_err_r, parity_err_s;
`endif

  // Shift one received bit into the word in the configured direction.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             b);
    logic [WIDTH-1:0] res;
    if (MSB_FIRST != 0) begin
      res = {cur[WIDTH-2:0], b};
    end else begin
      res = {b, cur[WIDTH-1:1]};
    end
    return res;
  endfunction

  // Next-state and next-output logic; everything moves only on bit_en except ack.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    pout_s      = pout_r;
    valid_s     = valid_r;
    frame_err_s = frame_err_r;
    overrun_s   = overrun_r;
    bit_cnt_s   = bit_cnt_r;
`ifdef SIPO_PARITY_CHECK_EN
    par_acc_s    = par_acc_r;
    par_bad_s    = par_bad_r;
    parity_err_s = parity_err_r;
`endif

    if (ack && valid_r) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end

    if (bit_en) begin
      case (state_r)
        ST_IDLE: begin
          if (!Sin) begin
            state_s   = ST_DATA;
            bit_cnt_s = '0;
`ifdef SIPO_PARITY_CHECK_EN
            par_acc_s = 1'b0;
            par_bad_s = 1'b0;
`endif
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_s   = shift_in(shift_r, Sin);
          bit_cnt_s = bit_cnt_r + CNT_W'(1);
`ifdef SIPO_PARITY_CHECK_EN
          par_acc_s = par_acc_r ^ Sin;
`endif
          if (bit_cnt_r == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_CHECK_EN
            state_s = ST_PARITY;
`else
            state_s = ST_STOP;
`endif
          end else begin
            state_s = ST_DATA;
          end
        end
`ifdef SIPO_PARITY_CHECK_EN
        ST_PARITY: begin
          // Even parity: data XOR parity bit must be zero.
          if ((par_acc_r ^ Sin) != 1'b0) begin
            par_bad_s    = 1'b1;
            parity_err_s = 1'b1;
          end else begin
            par_bad_s = 1'b0;
          end
          state_s = ST_STOP;
        end
`endif
        ST_STOP: begin
          if (Sin) begin
`ifdef SIPO_PARITY_CHECK_EN
            if (!par_bad_r) begin
`else
            if (1'b1) begin
`endif
              pout_s  = shift_r;
              valid_s = 1'b1;
              // A same-cycle ack releases the old word, so no overrun.
              if (valid_r && !ack) begin
                overrun_s = 1'b1;
              end else begin
                overrun_s = overrun_r;
              end
            end else begin
              pout_s = pout_r;
            end
          end else begin
            frame_err_s = 1'b1;
          end
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      shift_r     <= '0;
      pout_r      <= '0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      bit_cnt_r   <= '0;
`ifdef SIPO_PARITY_CHECK_EN
      par_acc_r    <= 1'b0;
      par_bad_r    <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      pout_r      <= pout_s;
      valid_r     <= valid_s;
      busy_r      <= busy_s;
      frame_err_r <= frame_err_s;
      overrun_r   <= overrun_s;
      bit_cnt_r   <= bit_cnt_s;
`ifdef SIPO_PARITY_CHECK_EN
      par_acc_r    <= par_acc_s;
      par_bad_r    <= par_bad_s;
      parity_err_r <= parity_err_s;
`endif
    end
  end

  assign Pout      = pout_r;
  assign valid     = valid_r;
  assign busy      = busy_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign bit_cnt   = bit_cnt_r;
`ifdef SIPO_PARITY_CHECK_EN
  assign parity_err = parity_err_r;
`endif

endmodule

// File: doc/shift_register_sipo_receiver.md
Name: shift_register_sipo_receiver

Overview:
- Serial-in, parallel-out receiver: the far end of the team's PISO shift-register link.
- Accepts one serial bit per strobe (`bit_en`, normally the debounced button pulse) and detects a start bit.
- Deserializes WIDTH data bits, checks the stop bit, and presents the word on a held parallel output with a valid/ack handshake.
- Sits between the debounce circuit and the LED/7-segment display logic.

Parameters:
- WIDTH, 8, number of data bits per frame (2..16).
- MSB_FIRST, 1, 1 = first data bit received lands in Pout[WIDTH-1]; 0 = first bit lands in Pout[0].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- bit_en  input  1  single-cycle strobe; Sin is sampled only in cycles where bit_en=1.
- Sin  input  1  serial data line, idle high.
- ack  input  1  consumer acknowledge; clears valid.
- Pout  output  WIDTH  last correctly framed data word.
- valid  output  1  Pout holds an unacknowledged word.
- busy  output  1  frame in progress (state != IDLE).
- frame_err  output  1  sticky; set on bad stop bit.
- overrun  output  1  sticky; set when a new word completes while valid=1.
- bit_cnt  output  log2(WIDTH)+1  data bits received in the current frame (for display).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; shift register, Pout and bit_cnt are 0; valid, busy, frame_err and overrun are 0. This takes effect immediately, including mid-frame; the partial word is discarded.
- Cycles with bit_en=0 change nothing except the ack handling below.
- State machine (all transitions occur only on bit_en=1 cycles):
  - IDLE: Sin=0 means a start bit; go to DATA with bit_cnt=0. Sin=1 means stay in IDLE.
  - DATA: shift Sin into the internal shift register.
    - MSB_FIRST=1: shift left, Sin enters bit 0.
    - MSB_FIRST=0: shift right, Sin enters bit WIDTH-1.
    - bit_cnt increments; when it reaches WIDTH, go to STOP.
  - STOP, Sin=1 (good stop bit):
    - Pout <= shift register and valid <= 1.
    - If valid was already 1 and ack=0 in this cycle, set overrun=1. Pout is still overwritten with the newest word.
    - Go to IDLE.
  - STOP, Sin=0 (bad stop bit): frame_err <= 1; Pout and valid unchanged; go to IDLE.
- busy = 1 in DATA and STOP. bit_cnt is registered and holds its final value (WIDTH) until the next start bit.
- Latency: valid rises on the clock edge that samples the stop bit, i.e. valid=1 in the cycle after that bit_en.
- Handshake:
  - ack=1 while valid=1 clears valid on the next edge.
  - ack while valid=0 has no effect.
  - If ack=1 in the same cycle a good stop bit is sampled, the new word wins: valid=1, Pout = new word, no overrun.
- frame_err and overrun are sticky and are cleared only by reset.
- Sin is treated as already synchronous to clk; a two-flop synchronizer is outside this block.

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - An even-parity bit follows the last data bit. The state machine becomes IDLE -> DATA -> PARITY -> STOP.
  - A parity_err output (1 bit, sticky, reset 0) is added.
  - In PARITY, the received bit XOR the XOR of the data bits must equal 0; otherwise parity_err <= 1.
  - On a parity mismatch, the word is still not loaded at STOP: Pout and valid stay unchanged.
  - A frame is 1 start + WIDTH data + 1 parity + 1 stop = 11 strobes for WIDTH=8.
- Undefined: no PARITY state and no parity_err port; a frame is WIDTH+2 strobes.

Test Plan:
- Reset state: hold reset=0 for 3 cycles with random Sin/bit_en → all outputs 0, busy=0.
- Good frame: WIDTH=8, MSB_FIRST=1; strobe Sin = 0, 1,0,1,0,0,1,0,1, 1 → Pout=8'hA5, valid=1 one cycle after the 10th strobe. Pulse ack → valid=0 on the next edge. bit_cnt=8 and busy=0 after the frame.
- LSB-first: MSB_FIRST=0, same bit stream → Pout=8'hA5 bit-reversed = 8'hA5 is symmetric, so use data bits 1,1,0,0,0,0,0,0 → Pout=8'h03.
- Framing error: a valid frame with stop bit 0 → frame_err=1, valid stays 0, Pout keeps its old value. The next good frame of 8'h3C then loads normally; frame_err stays 1.
- Overrun and simultaneous ack: two back-to-back frames 8'h11 then 8'h22 with no ack → Pout=8'h22, overrun=1. Repeat after reset, asserting ack in the same cycle as the second stop strobe → overrun=0, valid=1, Pout=8'h22.
- Reset mid-frame: assert reset after the 4th data bit; release, then send 8'hF0 → Pout=8'hF0 with no residue from the aborted frame. With SIPO_PARITY_CHECK_EN, sending a wrong parity bit → parity_err=1 and valid stays 0.
